// File: rtl/imem_fetch_ctrl.sv
// Instruction memory fetch controller: owns the instruction memory port while a loader
// fills it, then streams sequential fetches with stall, redirect and sticky fault handling.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 32,
   parameter bit          BOOT_LOAD = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_valid,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic        load_done,
   output logic        load_ready,
   output logic [7:0]  load_count,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        fault
);

   localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] fetch_ptr;
   logic [31:0] fetch_next;
   logic        write_legal;
   logic        redirect_legal;

   assign write_legal    = (load_addr[1:0] == 2'b00) && (load_addr < LIMIT);
   assign redirect_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc < LIMIT);
   assign fetch_next     = ((fetch_ptr + 32'd4) >= LIMIT) ? 32'd0 : (fetch_ptr + 32'd4);

   // The memory write strobe is masked by rst_n so a reset cycle never disturbs memory.
   always_comb begin
      state_next = state;
      load_ready = 1'b0;
      mem_addr   = 32'd0;
      mem_we     = 1'b0;
      mem_wdata  = 32'd0;
      case (state)
         LOAD: begin
            load_ready = 1'b1;
            mem_addr   = load_addr;
            mem_wdata  = load_data;
            mem_we     = load_valid && write_legal && rst_n;
            if (load_done) state_next = RUN;
         end
         RUN: begin
            mem_addr = fetch_ptr;
            if (redirect_valid && !redirect_legal) state_next = FAULT;
         end
         FAULT: state_next = FAULT;
         default: state_next = FAULT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= BOOT_LOAD ? LOAD : RUN;
         fetch_ptr   <= RESET_PC;
         pc          <= RESET_PC;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         fault       <= 1'b0;
         load_count  <= 8'd0;
      end else begin
         state <= state_next;
         case (state)
            LOAD: begin
               if (mem_we && (load_count != 8'hFF)) load_count <= load_count + 8'd1;
               if (load_done) fetch_ptr <= RESET_PC;
            end
            RUN: begin
               // Redirect outranks stall; the bubble keeps the stale instr/pc but marks them invalid.
               if (redirect_valid) begin
                  instr_valid <= 1'b0;
                  if (redirect_legal) fetch_ptr <= redirect_pc;
                  else fault <= 1'b1;
               end else if (!stall) begin
                  instr       <= mem_rdata;
                  pc          <= fetch_ptr;
                  instr_valid <= 1'b1;
                  fetch_ptr   <= fetch_next;
               end
            end
            default: begin
               instr_valid <= 1'b0;
               fault       <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a behavioural model tracks the boot-load instance
// every cycle, directed sequences pin known values, and a BOOT_LOAD=0 instance checks direct boot.
module tb_imem_fetch_ctrl;

   localparam int          DEPTH    = 32;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] LIMIT    = 32'(DEPTH * 4);
   localparam int MODE_LOAD = 0;
   localparam int MODE_RUN  = 1;
   localparam int MODE_FLT  = 2;

   logic        clk;
   logic        rst_n;
   logic        load_valid;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        load_done;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        load_ready, mem_we, instr_valid, fault;
   logic [7:0]  load_count;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instr;

   logic        b0_load_ready, b0_mem_we, b0_instr_valid, b0_fault;
   logic [7:0]  b0_load_count;
   logic [31:0] b0_mem_addr, b0_mem_wdata, b0_mem_rdata, b0_pc, b0_instr;

   logic [31:0] imem [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] word0_init;
   int          we_pulses = 0;

   int          m_mode = MODE_LOAD;
   logic [31:0] m_fp, m_pc, m_instr;
   logic        m_valid, m_fault;
   int          m_count = 0;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   imem_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .BOOT_LOAD(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
      .load_ready(load_ready), .load_count(load_count),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .pc(pc), .instr(instr), .instr_valid(instr_valid), .fault(fault)
   );

   imem_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .BOOT_LOAD(1'b0)) u_dut_boot0 (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
      .load_ready(b0_load_ready), .load_count(b0_load_count),
      .mem_addr(b0_mem_addr), .mem_we(b0_mem_we), .mem_wdata(b0_mem_wdata), .mem_rdata(b0_mem_rdata),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .pc(b0_pc), .instr(b0_instr), .instr_valid(b0_instr_valid), .fault(b0_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_rdata    = imem[mem_addr[6:2]];
   assign b0_mem_rdata = imem[b0_mem_addr[6:2]];

   // Physical memory: only the boot-load instance is allowed to write it.
   always @(posedge clk) begin
      if (mem_we) begin
         imem[mem_addr[6:2]] <= mem_wdata;
         we_pulses <= we_pulses + 1;
      end
   end

   function automatic bit isLegal(input logic [31:0] a);
      return ((a % 4) == 0) && (a < LIMIT);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: what the controller must do at each rising edge, in terms of the spec's rules.
   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_mode = MODE_LOAD; m_fp = RESET_PC; m_pc = RESET_PC;
            m_instr = 32'd0; m_valid = 1'b0; m_fault = 1'b0; m_count = 0;
         end else if (m_mode == MODE_LOAD) begin
            if (load_valid && isLegal(load_addr)) begin
               ref_mem[load_addr[6:2]] = load_data;
               if (m_count < 255) m_count++;
            end
            if (load_done) begin
               m_mode = MODE_RUN;
               m_fp   = RESET_PC;
            end
         end else if (m_mode == MODE_RUN) begin
            if (redirect_valid) begin
               m_valid = 1'b0;
               if (isLegal(redirect_pc)) m_fp = redirect_pc;
               else begin
                  m_mode  = MODE_FLT;
                  m_fault = 1'b1;
               end
            end else if (!stall) begin
               m_instr = ref_mem[m_fp[6:2]];
               m_pc    = m_fp;
               m_valid = 1'b1;
               m_fp    = (m_fp + 4) % LIMIT;
            end
         end
      end
   end

   // Compare process: every cycle on the falling edge, once the model is defined.
   initial begin
      logic [31:0] e_addr, e_wdata;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            e_addr  = (m_mode == MODE_LOAD) ? load_addr : (m_mode == MODE_RUN) ? m_fp : 32'd0;
            e_wdata = (m_mode == MODE_LOAD) ? load_data : 32'd0;
            checkOutput("load_ready", 32'(load_ready), 32'(m_mode == MODE_LOAD));
            checkOutput("mem_we", 32'(mem_we),
                        32'((m_mode == MODE_LOAD) && rst_n && load_valid && isLegal(load_addr)));
            checkOutput("mem_addr", mem_addr, e_addr);
            checkOutput("mem_wdata", mem_wdata, e_wdata);
            checkOutput("load_count", 32'(load_count), 32'(m_count));
            checkOutput("instr_valid", 32'(instr_valid), 32'(m_valid));
            checkOutput("fault", 32'(fault), 32'(m_fault));
            checkOutput("pc", pc, m_pc);
            checkOutput("instr", instr, m_instr);
            checkOutput("boot0_load_ready", 32'(b0_load_ready), 32'd0);
            checkOutput("boot0_mem_we", 32'(b0_mem_we), 32'd0);
         end
      end
   end

   task automatic applyStimulus(input logic rn, input logic lv, input logic [31:0] la,
                                input logic [31:0] ld, input logic dn, input logic st,
                                input logic rv, input logic [31:0] rp);
      rst_n = rn; load_valid = lv; load_addr = la; load_data = ld; load_done = dn;
      stall = st; redirect_valid = rv; redirect_pc = rp;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic randomLoadPhase(input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = ($urandom_range(0, 9) < 7) ? 32'($urandom_range(0, DEPTH - 1) * 4) : 32'($urandom_range(0, 255));
         applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), a, $urandom,
                       1'b0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      end
      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      applyStimulus(1'b1, $urandom_range(0, 1), a, $urandom, 1'b1, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic randomRunPhase(input int n);
      logic [31:0] rp;
      for (int i = 0; i < n; i++) begin
         rp = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, DEPTH - 1) * 4);
         applyStimulus(($urandom_range(0, 99) != 0), $urandom_range(0, 1), 32'($urandom_range(0, DEPTH - 1) * 4),
                       $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 11) == 0), rp);
      end
   endtask

   logic [31:0] wrap_seq [4];

   initial begin
      wrap_seq[0] = 32'h78; wrap_seq[1] = 32'h7C; wrap_seq[2] = 32'h00; wrap_seq[3] = 32'h04;
      for (int i = 0; i < DEPTH; i++) begin
         imem[i]    = $urandom;
         ref_mem[i] = imem[i];
      end
      word0_init = imem[0];

      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk_en = 1'b1;
      applyStimulus(1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("rst_load_count", 32'(load_count), 32'd0);
      checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
      checkOutput("rst_pc", pc, 32'd0);
      checkOutput("rst_load_ready", 32'(load_ready), 32'd1);

      applyStimulus(1'b1, 1'b1, 32'h4, 32'h1234_50B7, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("boot0_first_valid", 32'(b0_instr_valid), 32'd1);
      checkOutput("boot0_first_pc", b0_pc, RESET_PC);
      checkOutput("boot0_first_instr", b0_instr, word0_init);
      applyStimulus(1'b1, 1'b1, 32'hC, 32'h00A0_0113, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("two_loads_count", 32'(load_count), 32'd2);
      applyStimulus(1'b1, 1'b1, 32'h2, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h80, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("illegal_loads_count", 32'(load_count), 32'd2);
      checkOutput("we_pulses", 32'(we_pulses), 32'd2);

      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("run_load_ready", 32'(load_ready), 32'd0);
      checkOutput("run_first_bubble", 32'(instr_valid), 32'd0);
      idle();
      checkOutput("first_fetch_valid", 32'(instr_valid), 32'd1);
      checkOutput("first_fetch_pc", pc, 32'h0);
      idle();
      checkOutput("fetch_pc4", pc, 32'h4);
      checkOutput("fetch_instr4", instr, 32'h1234_50B7);
      idle();
      idle();
      checkOutput("fetch_pcC", pc, 32'hC);
      checkOutput("fetch_instrC", instr, 32'h00A0_0113);

      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h78);
      checkOutput("redirect_bubble", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         idle();
         checkOutput("wrap_pc", pc, wrap_seq[i]);
      end

      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("stall_hold_pc", pc, 32'h4);
      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h10);
      checkOutput("stall_redirect_valid", 32'(instr_valid), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
      idle();
      checkOutput("after_redirect_valid", 32'(instr_valid), 32'd1);
      checkOutput("after_redirect_pc", pc, 32'h10);

      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h6);
      checkOutput("fault_set", 32'(fault), 32'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'h8, $urandom, 1'b1, 1'b0, 1'b1, 32'h8);
      checkOutput("fault_sticky", 32'(fault), 32'd1);
      checkOutput("fault_no_valid", 32'(instr_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("fault_cleared", 32'(fault), 32'd0);
      checkOutput("count_cleared", 32'(load_count), 32'd0);

      for (int i = 0; i < 270; i++)
         applyStimulus(1'b1, 1'b1, 32'($urandom_range(0, DEPTH - 1) * 4), $urandom, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("count_saturate", 32'(load_count), 32'd255);
      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
      randomRunPhase(60);

      for (int ep = 0; ep < 8; ep++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
         randomLoadPhase($urandom_range(0, 40));
         randomRunPhase(150);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
